// File: rtl/mbr_prefetch_unit.sv
// Instruction-byte prefetcher: issues single-byte reads on memory port B and
// queues returned bytes in a small FIFO that feeds MBR/MBRU.
module mbr_prefetch_unit #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              fetch_pop,
   output logic              mbr_valid,
   output logic [31:0]       mbr,
   output logic [31:0]       mbru,
   output logic [ADDR_W-1:0] pc_out,
   output logic              ren_B,
   output logic [ADDR_W-1:0] addr_B,
   input  logic [7:0]        rdata_B
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic {
      S_REQ,
      S_DATA
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] fptr;
   logic [ADDR_W-1:0] head_pc;
   logic [CNT_W-1:0]  count;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [7:0]        fifo_mem [DEPTH];
   logic [7:0]        head_byte;
   logic              push;
   logic              pop;

   // Only one read is ever in flight, so checking count at issue time is enough
   // to guarantee the later push always finds room.
   always_comb begin
      state_nx = state;
      ren_B    = 1'b0;
      push     = 1'b0;
      case (state)
         S_REQ: begin
            if (count < CNT_W'(DEPTH) && !pc_load && !rst) begin
               ren_B    = 1'b1;
               state_nx = S_DATA;
            end
         end
         S_DATA: begin
            push     = !pc_load && !rst;
            state_nx = S_REQ;
         end
         default: state_nx = S_REQ;
      endcase
   end

   assign pop       = fetch_pop && mbr_valid && !pc_load && !rst;
   assign addr_B    = fptr;
   assign mbr_valid = (count != '0);
   assign head_byte = fifo_mem[rd_ptr];
   assign mbru      = mbr_valid ? {24'b0, head_byte} : 32'b0;
   assign mbr       = mbr_valid ? {{24{head_byte[7]}}, head_byte} : 32'b0;
   assign pc_out    = head_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_REQ;
         fptr    <= '0;
         head_pc <= '0;
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else if (pc_load) begin
         state   <= S_REQ;
         fptr    <= pc_in;
         head_pc <= pc_in;
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         state <= state_nx;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            fptr   <= fptr + 1'b1;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            head_pc <= head_pc + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: push is already suppressed by rst and pc_load.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= rdata_B;
      end
   end

endmodule

// File: tb/tb_mbr_prefetch_unit.sv
// Scoreboard bench for mbr_prefetch_unit: expected byte stream is the memory
// contents from the last load address onward, checked on every accepted pop.
module tb_mbr_prefetch_unit;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_load = 1'b0;
   logic [31:0] pc_in = 32'h0;
   logic        fetch_pop = 1'b0;
   logic        mbr_valid;
   logic [31:0] mbr;
   logic [31:0] mbru;
   logic [31:0] pc_out;
   logic        ren_B;
   logic [31:0] addr_B;
   logic [7:0]  rdata_B;
   logic [31:0] word_q;

   int total = 0;
   int bad = 0;
   int pops_seen = 0;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_next;

   always #5 clk = ~clk;

   mbr_prefetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .pc_load(pc_load), .pc_in(pc_in),
      .fetch_pop(fetch_pop), .mbr_valid(mbr_valid), .mbr(mbr), .mbru(mbru),
      .pc_out(pc_out), .ren_B(ren_B), .addr_B(addr_B), .rdata_B(rdata_B)
   );

   // Memory image: word 0 is 0x84332211 (little-endian), everything else hashed.
   function automatic logic [7:0] byte_of(logic [31:0] a);
      logic [31:0] w0;
      w0 = 32'h8433_2211;
      if (a < 32'd4) return 8'(w0 >> {a[1:0], 3'b000});
      return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'hA7;
   endfunction

   // Registered word read; byte lane chosen by the address still present in the data cycle.
   always @(posedge clk) begin
      if (ren_B) begin
         word_q <= {byte_of({addr_B[31:2], 2'd3}), byte_of({addr_B[31:2], 2'd2}),
                    byte_of({addr_B[31:2], 2'd1}), byte_of({addr_B[31:2], 2'd0})};
      end
   end
   assign rdata_B = 8'(word_q >> {addr_B[1:0], 3'b000});

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   task automatic topUp();
      while (exp_q.size() < 32) begin
         exp_t e;
         e.addr = exp_next;
         e.data = byte_of(exp_next);
         exp_q.push_back(e);
         exp_next = exp_next + 32'd1;
      end
   endtask

   task automatic restartModel(input logic [31:0] base);
      exp_q.delete();
      exp_next = base;
      topUp();
   endtask

   task automatic applyStimulus(input logic r, input logic ld, input logic [31:0] pin, input logic pop);
      @(posedge clk);
      #1;
      rst       = r;
      pc_load   = ld;
      pc_in     = pin;
      fetch_pop = pop;
      if (r) restartModel(32'h0);
      else if (ld) restartModel(pin);
      topUp();
   endtask

   // Monitor: every accepted pop must present the next byte of the expected stream.
   always @(negedge clk) begin
      if (!rst) begin
         if (!mbr_valid) begin
            checkOutput("mbr_idle", mbr, 32'h0);
            checkOutput("mbru_idle", mbru, 32'h0);
         end else if (fetch_pop && !pc_load) begin
            if (exp_q.size() == 0) begin
               checkOutput("queue_nonempty", 32'd0, 32'd1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               pops_seen++;
               checkOutput("pop_mbru", mbru, {24'b0, e.data});
               checkOutput("pop_mbr", mbr, {{24{e.data[7]}}, e.data});
               checkOutput("pop_pc_out", pc_out, e.addr);
            end
         end
      end
   end

   initial begin
      int pop_pct;
      logic found;

      // Reset and idle fetch up to full
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("ren_in_rst", 32'(ren_B), 32'd0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
         @(negedge clk);
         if (i == 0) begin
            checkOutput("rst_valid", 32'(mbr_valid), 32'd0);
            checkOutput("rst_pc_out", pc_out, 32'h0);
            checkOutput("rst_addr_B", addr_B, 32'h0);
         end
         checkOutput("ren_pattern", 32'(ren_B), 32'((i < 8) && (i % 2 == 0)));
         if (i < 8 && i % 2 == 0) checkOutput("fill_addr", addr_B, 32'(i / 2));
      end

      // One pop while full allows exactly one more read, starting next cycle
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("full_ren", 32'(ren_B), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("resume_ren", 32'(ren_B), 32'd1);
      checkOutput("resume_addr", addr_B, 32'h4);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
         @(negedge clk);
         checkOutput("refull_ren", 32'(ren_B), 32'd0);
      end
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

      // Load latency, with a concurrent pop that must be discarded
      applyStimulus(1'b0, 1'b1, 32'h10, 1'b1);
      @(negedge clk);
      checkOutput("load_ren", 32'(ren_B), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("lat_ren1", 32'(ren_B), 32'd1);
      checkOutput("lat_addr1", addr_B, 32'h10);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("lat_ren2", 32'(ren_B), 32'd0);
      checkOutput("lat_addr2", addr_B, 32'h10);
      checkOutput("lat_valid2", 32'(mbr_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("lat_valid3", 32'(mbr_valid), 32'd1);
      checkOutput("lat_mbru3", mbru, {24'b0, byte_of(32'h10)});
      checkOutput("lat_pc3", pc_out, 32'h10);

      // Load during a data cycle drops the in-flight byte
      applyStimulus(1'b0, 1'b1, 32'h5, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("sd_addr5", addr_B, 32'h5);
      applyStimulus(1'b0, 1'b1, 32'h20, 1'b0);
      @(negedge clk);
      checkOutput("sd_ren", 32'(ren_B), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("sd_req_addr", addr_B, 32'h20);
      checkOutput("empty_pop_valid", 32'(mbr_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("empty_pop_valid2", 32'(mbr_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("sd_first_mbru", mbru, {24'b0, byte_of(32'h20)});
      checkOutput("sd_first_pc", pc_out, 32'h20);
      checkOutput("sd_next_addr", addr_B, 32'h21);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("pp_valid", 32'(mbr_valid), 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("pp_valid_after", 32'(mbr_valid), 32'd1);
      checkOutput("pp_pc", pc_out, 32'h21);
      checkOutput("pp_mbru", mbru, {24'b0, byte_of(32'h21)});
      checkOutput("pp_next_addr", addr_B, 32'h22);

      // Address wrap
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
      for (int j = 1; j <= 6; j++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
         @(negedge clk);
         checkOutput("wrap_ren", 32'(ren_B), 32'(j % 2));
         if (j == 1) checkOutput("wrap_addr1", addr_B, 32'hFFFF_FFFE);
         if (j == 3) checkOutput("wrap_addr3", addr_B, 32'hFFFF_FFFF);
         if (j == 5) checkOutput("wrap_addr5", addr_B, 32'h0);
         if (j == 5) checkOutput("wrap_pc5", pc_out, 32'hFFFF_FFFE);
      end
      for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

      // Reset asserted in a data cycle
      found = 1'b0;
      for (int j = 0; j < 6 && !found; j++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
         @(negedge clk);
         found = ren_B;
      end
      checkOutput("find_req", 32'(found), 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("rst_sd_valid", 32'(mbr_valid), 32'd0);
      checkOutput("rst_sd_addr", addr_B, 32'h0);
      checkOutput("rst_sd_pc", pc_out, 32'h0);

      // Randomized traffic
      pop_pct = 50;
      for (int n = 0; n < 3000; n++) begin
         logic r;
         logic ld;
         logic [31:0] pin;
         if (n % 200 == 0) pop_pct = $urandom_range(0, 100);
         r   = ($urandom_range(0, 299) == 0);
         ld  = !r && ($urandom_range(0, 39) == 0);
         pin = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 5))) : $urandom;
         applyStimulus(r, ld, pin, ($urandom_range(0, 99) < pop_pct));
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("pops_seen", 32'(pops_seen > 100), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
